// File: rtl/native_to_wishbone_bridge.sv
// Native single-beat request responder that replays each request as one Wishbone classic
// cycle, with a one-entry request buffer, a bus timeout and sticky error flags.
module native_to_wishbone_bridge #(
  parameter int          address_width = 16,
  parameter int          TimeoutCycles = 255,
  parameter logic [31:0] TimeoutData   = 32'hDEADBEEF
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] address_i,
  input  logic [31:0]              data_i,
  input  logic [3:0]               write_strb_i,
  input  logic                     data_valid_i,
  output logic [31:0]              data_o,
  output logic                     data_valid_o,
  output logic [31:0]              o_wb_adr,
  output logic [31:0]              o_wb_dat,
  output logic [3:0]               o_wb_sel,
  output logic                     o_wb_we,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  input  logic [31:0]              i_wb_rdt,
  input  logic                     i_wb_ack,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     overflow_o,
  input  logic                     clear_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_r;
  logic                     buf_valid_r;
  logic [address_width-1:0] buf_adr_r;
  logic [31:0]              buf_dat_r;
  logic [3:0]               buf_strb_r;
  logic [31:0]              cnt_r;
  logic [31:0]              data_r;
  logic                     data_valid_r;
  logic [31:0]              adr_r;
  logic [31:0]              dat_r;
  logic [3:0]               sel_r;
  logic                     we_r;
  logic                     cyc_r;
  logic                     timeout_r;
  logic                     overflow_r;

  logic accept_live_s;
  logic store_s;
  logic drop_s;
  logic timeout_evt_s;

  // Word-aligned, zero-extended Wishbone address.
  function automatic logic [31:0] wb_addr(input logic [address_width-1:0] a);
    return 32'(a) & 32'hFFFF_FFFC;
  endfunction

  // Request routing: live capture, buffering or drop, plus timeout expiry detection.
  always_comb begin
    accept_live_s = 1'b0;
    store_s       = 1'b0;
    drop_s        = 1'b0;
    timeout_evt_s = 1'b0;
    if ((state_r == IDLE) && !buf_valid_r) begin
      accept_live_s = data_valid_i;
    end else begin
      store_s = data_valid_i && !buf_valid_r;
      drop_s  = data_valid_i && buf_valid_r;
    end
    if ((state_r == BUS) && !i_wb_ack && (TimeoutCycles != 0)) begin
      timeout_evt_s = (cnt_r == 32'(TimeoutCycles - 1));
    end else begin
      timeout_evt_s = 1'b0;
    end
  end

  // Main FSM, Wishbone output registers, request buffer and sticky flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      buf_valid_r  <= 1'b0;
      buf_adr_r    <= '0;
      buf_dat_r    <= 32'd0;
      buf_strb_r   <= 4'd0;
      cnt_r        <= 32'd0;
      data_r       <= 32'd0;
      data_valid_r <= 1'b0;
      adr_r        <= 32'd0;
      dat_r        <= 32'd0;
      sel_r        <= 4'd0;
      we_r         <= 1'b0;
      cyc_r        <= 1'b0;
      timeout_r    <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (buf_valid_r) begin
            adr_r   <= wb_addr(buf_adr_r);
            dat_r   <= buf_dat_r;
            sel_r   <= (buf_strb_r != 4'd0) ? buf_strb_r : 4'hF;
            we_r    <= (buf_strb_r != 4'd0);
            cyc_r   <= 1'b1;
            state_r <= BUS;
          end else if (accept_live_s) begin
            adr_r   <= wb_addr(address_i);
            dat_r   <= data_i;
            sel_r   <= (write_strb_i != 4'd0) ? write_strb_i : 4'hF;
            we_r    <= (write_strb_i != 4'd0);
            cyc_r   <= 1'b1;
            state_r <= BUS;
          end else begin
            state_r <= IDLE;
          end
        end
        BUS: begin
          cnt_r <= cnt_r + 32'd1;
          // Ack has priority over a timeout expiring in the same cycle.
          if (i_wb_ack) begin
            if (!we_r) data_r <= i_wb_rdt;
            cyc_r        <= 1'b0;
            data_valid_r <= 1'b1;
            state_r      <= RESP;
          end else if (timeout_evt_s) begin
            if (!we_r) data_r <= TimeoutData;
            cyc_r        <= 1'b0;
            data_valid_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            state_r <= BUS;
          end
        end
        RESP: begin
          cnt_r   <= 32'd0;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= 32'd0;
          cyc_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase

      if (store_s) begin
        buf_valid_r <= 1'b1;
        buf_adr_r   <= address_i;
        buf_dat_r   <= data_i;
        buf_strb_r  <= write_strb_i;
      end else if ((state_r == IDLE) && buf_valid_r) begin
        buf_valid_r <= 1'b0;
      end else begin
        buf_valid_r <= buf_valid_r;
      end

      // A set event wins over a simultaneous clear.
      if (timeout_evt_s) begin
        timeout_r <= 1'b1;
      end else if (clear_i) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end

      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_i) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign data_o       = data_r;
  assign data_valid_o = data_valid_r;
  assign o_wb_adr     = adr_r;
  assign o_wb_dat     = dat_r;
  assign o_wb_sel     = sel_r;
  assign o_wb_we      = we_r;
  assign o_wb_cyc     = cyc_r;
  assign o_wb_stb     = cyc_r;
  assign busy_o       = (state_r != IDLE) || buf_valid_r;
  assign timeout_o    = timeout_r;
  assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_native_to_wishbone_bridge.sv
// Directed self-checking bench for native_to_wishbone_bridge (timeout shortened to 8 cycles).
module tb_native_to_wishbone_bridge;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [15:0] address_i = 16'd0;
  logic [31:0] data_i = 32'd0;
  logic [3:0]  write_strb_i = 4'd0;
  logic        data_valid_i = 1'b0;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt = 32'd0;
  logic        i_wb_ack = 1'b0;
  logic        busy_o;
  logic        timeout_o;
  logic        overflow_o;
  logic        clear_i = 1'b0;

  int checks = 0;
  int errors = 0;

  native_to_wishbone_bridge #(
    .address_width(16),
    .TimeoutCycles(8),
    .TimeoutData(32'hDEADBEEF)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .address_i(address_i), .data_i(data_i),
    .write_strb_i(write_strb_i), .data_valid_i(data_valid_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
    .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .busy_o(busy_o), .timeout_o(timeout_o),
    .overflow_o(overflow_o), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    tick();
    tick();
    checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin errors++; $display("FAIL rst_cyc got %0b/%0b exp 0/0", o_wb_cyc, o_wb_stb); end
    checks++; if (data_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_dv_busy got %0b/%0b exp 0/0", data_valid_o, busy_o); end
    checks++; if (data_o !== 32'd0 || o_wb_adr !== 32'd0) begin errors++; $display("FAIL rst_data_adr got %h/%h exp 0/0", data_o, o_wb_adr); end
    checks++; if (timeout_o !== 1'b0 || overflow_o !== 1'b0) begin errors++; $display("FAIL rst_flags got %0b/%0b exp 0/0", timeout_o, overflow_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    address_i = 16'h0104; write_strb_i = 4'd0; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1) begin errors++; $display("FAIL rd_cyc got %0b/%0b exp 1/1", o_wb_cyc, o_wb_stb); end
    checks++; if (o_wb_adr !== 32'h00000104) begin errors++; $display("FAIL rd_adr got %h exp 00000104", o_wb_adr); end
    checks++; if (o_wb_sel !== 4'hF || o_wb_we !== 1'b0) begin errors++; $display("FAIL rd_sel_we got %h/%0b exp f/0", o_wb_sel, o_wb_we); end
    tick();
    tick();
    checks++; if (o_wb_cyc !== 1'b1 || data_valid_o !== 1'b0) begin errors++; $display("FAIL rd_wait got cyc %0b dv %0b exp 1/0", o_wb_cyc, data_valid_o); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFEF00D;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_resp got dv %0b data %h exp 1/cafef00d", data_valid_o, data_o); end
    checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL rd_cyc_drop got %0b exp 0", o_wb_cyc); end
    tick();
    checks++; if (data_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rd_pulse_end got dv %0b busy %0b exp 0/0", data_valid_o, busy_o); end
  endtask

  task automatic test_byte_write();
    address_i = 16'h0203; data_i = 32'h000000AB; write_strb_i = 4'b1000; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0; write_strb_i = 4'd0;
    checks++; if (o_wb_adr !== 32'h00000200 || o_wb_dat !== 32'h000000AB) begin errors++; $display("FAIL wr_adr_dat got %h/%h exp 00000200/000000ab", o_wb_adr, o_wb_dat); end
    checks++; if (o_wb_sel !== 4'b1000 || o_wb_we !== 1'b1) begin errors++; $display("FAIL wr_sel_we got %h/%0b exp 8/1", o_wb_sel, o_wb_we); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'h11111111;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_resp got dv %0b data %h exp 1/cafef00d", data_valid_o, data_o); end
    tick();
    checks++; if (data_valid_o !== 1'b0) begin errors++; $display("FAIL wr_pulse_end got %0b exp 0", data_valid_o); end
  endtask

  task automatic test_buffering();
    address_i = 16'h0010; write_strb_i = 4'd0; data_valid_i = 1'b1;
    tick();
    address_i = 16'h0020; data_i = 32'h00001111; write_strb_i = 4'hF;
    tick();
    checks++; if (busy_o !== 1'b1 || overflow_o !== 1'b0 || o_wb_adr !== 32'h00000010) begin errors++; $display("FAIL buf_store got busy %0b ovf %0b adr %h exp 1/0/00000010", busy_o, overflow_o, o_wb_adr); end
    address_i = 16'h0030; write_strb_i = 4'd0;
    tick();
    data_valid_i = 1'b0;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL buf_overflow got %0b exp 1", overflow_o); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'hA0A0A0A0;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hA0A0A0A0) begin errors++; $display("FAIL buf_first_resp got dv %0b data %h exp 1/a0a0a0a0", data_valid_o, data_o); end
    tick();
    checks++; if (o_wb_cyc !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL buf_idle got cyc %0b busy %0b exp 0/1", o_wb_cyc, busy_o); end
    tick();
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h00000020 || o_wb_we !== 1'b1 || o_wb_dat !== 32'h00001111) begin errors++; $display("FAIL buf_second_bus got cyc %0b adr %h we %0b dat %h exp 1/00000020/1/00001111", o_wb_cyc, o_wb_adr, o_wb_we, o_wb_dat); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'h22222222;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hA0A0A0A0) begin errors++; $display("FAIL buf_second_resp got dv %0b data %h exp 1/a0a0a0a0", data_valid_o, data_o); end
    tick();
    checks++; if (overflow_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL buf_sticky got ovf %0b busy %0b exp 1/0", overflow_o, busy_o); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL buf_clear got %0b exp 0", overflow_o); end
  endtask

  task automatic test_timeout();
    int cyc_high;
    address_i = 16'h0040; write_strb_i = 4'd0; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    cyc_high = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_wb_cyc === 1'b1) cyc_high++;
      tick();
    end
    checks++; if (cyc_high !== 8) begin errors++; $display("FAIL to_cyc_len got %0d exp 8", cyc_high); end
    checks++; if (o_wb_cyc !== 1'b0 || data_valid_o !== 1'b1) begin errors++; $display("FAIL to_drop got cyc %0b dv %0b exp 0/1", o_wb_cyc, data_valid_o); end
    checks++; if (data_o !== 32'hDEADBEEF || timeout_o !== 1'b1) begin errors++; $display("FAIL to_data got %h flag %0b exp deadbeef/1", data_o, timeout_o); end
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_clear got %0b exp 0", timeout_o); end
    address_i = 16'h0044; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL to_cycle8_cyc got %0b exp 1", o_wb_cyc); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'h12345678;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'h12345678 || timeout_o !== 1'b0) begin errors++; $display("FAIL to_ack_wins got dv %0b data %h flag %0b exp 1/12345678/0", data_valid_o, data_o, timeout_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    address_i = 16'h0050; write_strb_i = 4'd0; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++; if (o_wb_cyc !== 1'b0 || busy_o !== 1'b0 || data_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst got cyc %0b busy %0b dv %0b exp 0/0/0", o_wb_cyc, busy_o, data_valid_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    tick();
    checks++; if (data_valid_o !== 1'b0 || o_wb_cyc !== 1'b0) begin errors++; $display("FAIL mid_stale got dv %0b cyc %0b exp 0/0", data_valid_o, o_wb_cyc); end
    address_i = 16'h0058; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    checks++; if (o_wb_adr !== 32'h00000058) begin errors++; $display("FAIL mid_fresh_adr got %h exp 00000058", o_wb_adr); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'h55AA55AA;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'h55AA55AA) begin errors++; $display("FAIL mid_fresh_resp got dv %0b data %h exp 1/55aa55aa", data_valid_o, data_o); end
    tick();
  endtask

  task automatic test_stray_ack();
    i_wb_ack = 1'b1; i_wb_rdt = 32'h99999999;
    tick();
    tick();
    i_wb_ack = 1'b0;
    checks++; if (data_valid_o !== 1'b0 || o_wb_cyc !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL stray_state got dv %0b cyc %0b busy %0b exp 0/0/0", data_valid_o, o_wb_cyc, busy_o); end
    checks++; if (data_o !== 32'h55AA55AA) begin errors++; $display("FAIL stray_data got %h exp 55aa55aa", data_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_buffering();
    test_timeout();
    test_reset_mid();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
